// File: rtl/aqed_dup_scheduler_pkg.sv
// Shared types and defaults for the A-QED original/duplicate scheduler.
// Optional watchdog is controlled by the AQED_WATCHDOG_EN macro.
package aqed_sched_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CNT_W_DEF   = 32;
    localparam int GAP_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_GAP     = 3'd2,
        ST_DUP     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5,
        ST_TIMEOUT = 3'd6
    } sched_state_e;

    // True while an ORIG/DUP pair is in flight (the states a flush aborts
    // and the watchdog observes).
    function automatic logic in_sequence(input sched_state_e st);
        case (st)
            ST_ARMED, ST_GAP, ST_DUP, ST_DRAIN: in_sequence = 1'b1;
            default:                            in_sequence = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aqed_dup_scheduler_if.sv
// Host write stream and core write port of the A-QED scheduler.
// The scheduler uses the slave view; the host/core side uses master.
interface aqed_dup_scheduler_if
    import aqed_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              wen_out;
    logic [DATA_W-1:0] data_out;
    logic              is_orig;
    logic              is_dup;
    logic              dut_valid_out;

    modport slave (
        input  host_valid, host_data, dut_valid_out,
        output host_ready, wen_out, data_out, is_orig, is_dup
    );

    modport master (
        output host_valid, host_data, dut_valid_out,
        input  host_ready, wen_out, data_out, is_orig, is_dup
    );
endinterface

// File: rtl/aqed_dup_scheduler_watchdog.sv
// Loadable saturating cycle counter; expire is raised on the enabled cycle
// that completes LIMIT counted cycles. Used when AQED_WATCHDOG_EN is defined.
module aqed_watchdog #(
    parameter int LIMIT = 1024,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    output logic expire
);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);
    localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count enabled cycles since the last load, holding at LIMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign expire = en & (count_r >= CNT_LAST);

endmodule

// File: rtl/aqed_dup_scheduler.sv
// A-QED duplicate scheduler: tags the first host write after arming as ORIG,
// passes dup_gap further writes, stalls the host one cycle to re-issue the
// ORIG data as DUP, then waits for the DUP result to leave the core.
// Optional watchdog (TIMEOUT state, sticky timeout flag) under AQED_WATCHDOG_EN.
module aqed_dup_scheduler
    import aqed_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_W   = GAP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 flush,
    input  logic                 start,
    input  logic [GAP_W-1:0]     dup_gap,
    aqed_dup_scheduler_if.slave  bus,
    output logic [CNT_W-1:0]     orig_idx,
    output logic [CNT_W-1:0]     dup_idx,
    output logic                 seq_done,
    output logic                 timeout
);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] IDX_NONE = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic [CNT_W-1:0]  in_count_r;
    logic [CNT_W-1:0]  out_count_r;
    logic [CNT_W-1:0]  orig_idx_r;
    logic [CNT_W-1:0]  dup_idx_r;
    logic [DATA_W-1:0] orig_data_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              seq_done_r;

    logic ready_s;
    logic fire_s;
    logic dup_wr_s;
    logic wen_s;
    logic load_orig_s;
    logic gap_dec_s;
    logic load_dup_s;
    logic clr_idx_s;
    logic set_done_s;
    logic clr_done_s;
    logic wd_load_s;
    logic wd_expire_s;
    logic set_to_s;
    logic clr_to_s;

    // Host is stalled only for the single DUP issue cycle or while flushing.
    assign ready_s  = ~flush & (state_r != ST_DUP);
    assign fire_s   = bus.host_valid & ready_s & clk_en;
    // A flush aborts the pending DUP, so no write is issued alongside it.
    assign dup_wr_s = (state_r == ST_DUP) & clk_en & ~flush;
    assign wen_s    = fire_s | dup_wr_s;

    assign bus.host_ready = ready_s;
    assign bus.wen_out    = wen_s;
    assign bus.data_out   = (state_r == ST_DUP) ? orig_data_r : bus.host_data;
    assign bus.is_orig    = fire_s & (state_r == ST_ARMED);
    assign bus.is_dup     = dup_wr_s;

    assign orig_idx = orig_idx_r;
    assign dup_idx  = dup_idx_r;
    assign seq_done = seq_done_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; flush beats watchdog beats start/fire.
    always_comb begin
        state_nxt_s = state_r;
        load_orig_s = 1'b0;
        gap_dec_s   = 1'b0;
        load_dup_s  = 1'b0;
        clr_idx_s   = 1'b0;
        set_done_s  = 1'b0;
        clr_done_s  = 1'b0;
        wd_load_s   = 1'b0;
        set_to_s    = 1'b0;
        clr_to_s    = 1'b0;
        if (!clk_en) begin
            state_nxt_s = state_r;
        end else if (flush) begin
            if (in_sequence(state_r)) begin
                state_nxt_s = ST_IDLE;
                clr_idx_s   = 1'b1;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (wd_expire_s) begin
            state_nxt_s = ST_TIMEOUT;
            set_to_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        state_nxt_s = ST_ARMED;
                        wd_load_s   = 1'b1;
                        clr_done_s  = 1'b1;
                        clr_to_s    = 1'b1;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_ARMED: begin
                    if (fire_s) begin
                        load_orig_s = 1'b1;
                        state_nxt_s = (dup_gap == GAP_ZERO) ? ST_DUP : ST_GAP;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_GAP: begin
                    if (fire_s) begin
                        gap_dec_s   = 1'b1;
                        state_nxt_s = (gap_cnt_r <= GAP_ONE) ? ST_DUP : ST_GAP;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end
                ST_DUP: begin
                    load_dup_s  = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.dut_valid_out && (out_count_r == dup_idx_r)) begin
                        set_done_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Transaction counters, captured ORIG data/indices and sticky done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_count_r  <= CNT_ZERO;
            out_count_r <= CNT_ZERO;
            orig_idx_r  <= IDX_NONE;
            dup_idx_r   <= IDX_NONE;
            orig_data_r <= {DATA_W{1'b0}};
            gap_cnt_r   <= GAP_ZERO;
            seq_done_r  <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                in_count_r  <= CNT_ZERO;
                out_count_r <= CNT_ZERO;
            end else begin
                if (wen_s) begin
                    in_count_r <= in_count_r + CNT_ONE;
                end
                if (bus.dut_valid_out) begin
                    out_count_r <= out_count_r + CNT_ONE;
                end
            end
            if (clr_idx_s) begin
                orig_idx_r <= IDX_NONE;
                dup_idx_r  <= IDX_NONE;
            end else begin
                if (load_orig_s) begin
                    orig_idx_r <= in_count_r;
                end
                if (load_dup_s) begin
                    dup_idx_r <= in_count_r;
                end
            end
            if (load_orig_s) begin
                orig_data_r <= bus.host_data;
                gap_cnt_r   <= dup_gap;
            end else if (gap_dec_s) begin
                gap_cnt_r <= gap_cnt_r - GAP_ONE;
            end
            if (set_done_s) begin
                seq_done_r <= 1'b1;
            end else if (clr_done_s) begin
                seq_done_r <= 1'b0;
            end
        end
    end

`ifdef AQED_WATCHDOG_EN
    logic wd_en_s;
    logic timeout_r;

    assign wd_en_s = clk_en & in_sequence(state_r);
    assign timeout = timeout_r;

    aqed_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .reset  (reset),
        .en     (wd_en_s),
        .load   (wd_load_s),
        .expire (wd_expire_s)
    );

    // Sticky timeout flag, cleared by the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else if (clk_en) begin
            if (set_to_s) begin
                timeout_r <= 1'b1;
            end else if (clr_to_s) begin
                timeout_r <= 1'b0;
            end
        end
    end
`else
    logic [34:0] unused_wd_s;

    assign wd_expire_s = 1'b0;
    assign timeout     = 1'b0;
    assign unused_wd_s = {set_to_s, clr_to_s, wd_load_s, TIMEOUT};
`endif

endmodule

// File: tb/tb_aqed_dup_scheduler.sv
// Self-checking bench for aqed_dup_scheduler: a cycle vector table for the
// main ORIG/GAP/DUP/DRAIN/DONE sequence, hand-written corner sequences, and a
// write scoreboard fed with the expected core writes as stimulus is driven.
module tb_aqed_dup_scheduler;

`ifdef AQED_WATCHDOG_EN
    localparam int TO_P = 16;
`else
    localparam int TO_P = 1024;
`endif
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    typedef struct {
        logic        start;
        logic        dv;
        logic        hv;
        logic [15:0] hd;
        logic        exp_hr;
        logic        exp_wen;
        logic [15:0] exp_data;
        logic        exp_orig;
        logic        exp_dup;
        logic        exp_done;
        logic [31:0] exp_oidx;
        logic [31:0] exp_didx;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        orig;
        logic        dup;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic        start;
    logic [7:0]  dup_gap;
    logic [31:0] orig_idx;
    logic [31:0] dup_idx;
    logic        seq_done;
    logic        timeout;

    int   n_pass  = 0;
    int   n_total = 0;
    wr_t  sb_q[$];
    vec_t vecs[12];

    aqed_dup_scheduler_if #(.DATA_W(16)) bus();

    aqed_dup_scheduler #(
        .DATA_W  (16),
        .CNT_W   (32),
        .GAP_W   (8),
        .TIMEOUT (TO_P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .flush    (flush),
        .start    (start),
        .dup_gap  (dup_gap),
        .bus      (bus),
        .orig_idx (orig_idx),
        .dup_idx  (dup_idx),
        .seq_done (seq_done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic set_in(input logic st, input logic fl, input logic ce,
                          input logic hv, input logic [15:0] hd, input logic dv);
        start             = st;
        flush             = fl;
        clk_en            = ce;
        bus.host_valid    = hv;
        bus.host_data     = hd;
        bus.dut_valid_out = dv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [15:0] d, input logic o, input logic u);
        wr_t w;
        w.data = d;
        w.orig = o;
        w.dup  = u;
        sb_q.push_back(w);
    endtask

    // Scoreboard: every core write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wen_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_write: got data %h orig %b dup %b, expected no write",
                         bus.data_out, bus.is_orig, bus.is_dup);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_write", {14'd0, bus.data_out, bus.is_orig, bus.is_dup},
                    {14'd0, e.data, e.orig, e.dup});
            end
        end
    end

    initial begin
        // start,dv,hv,hd | hr,wen,data,orig,dup,done,oidx,didx  (dup_gap=2)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, ONES,  ONES};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'hA0A0, 1'b1, 1'b1, 16'hA0A0, 1'b1, 1'b0, 1'b0, ONES,  ONES};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'hB1B1, 1'b1, 1'b1, 16'hB1B1, 1'b0, 1'b0, 1'b0, 32'd0, ONES};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'hC2C2, 1'b1, 1'b1, 16'hC2C2, 1'b0, 1'b0, 1'b0, 32'd0, ONES};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'hD3D3, 1'b0, 1'b1, 16'hA0A0, 1'b0, 1'b1, 1'b0, 32'd0, ONES};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'hD3D3, 1'b1, 1'b1, 16'hD3D3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd3};

        // Reset state.
        reset   = 1'b0;
        dup_gap = 8'd2;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_orig_idx", orig_idx, ONES);
        chk("rst_dup_idx", dup_idx, ONES);
        chk("rst_seq_done", {31'd0, seq_done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_wen", {31'd0, bus.wen_out}, 32'd0);
        step();
        reset = 1'b1;

        // Main sequence: A orig, B/C gap, DUP of A, D passes, 5 output pulses.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].start, 1'b0, 1'b1, vecs[i].hv, vecs[i].hd, vecs[i].dv);
            if (vecs[i].exp_wen) begin
                push_wr(vecs[i].exp_data, vecs[i].exp_orig, vecs[i].exp_dup);
            end
            @(negedge clk);
            chk($sformatf("v%0d_host_ready", i), {31'd0, bus.host_ready}, {31'd0, vecs[i].exp_hr});
            chk($sformatf("v%0d_wen", i), {31'd0, bus.wen_out}, {31'd0, vecs[i].exp_wen});
            chk($sformatf("v%0d_data", i), {16'd0, bus.data_out}, {16'd0, vecs[i].exp_data});
            chk($sformatf("v%0d_is_orig", i), {31'd0, bus.is_orig}, {31'd0, vecs[i].exp_orig});
            chk($sformatf("v%0d_is_dup", i), {31'd0, bus.is_dup}, {31'd0, vecs[i].exp_dup});
            chk($sformatf("v%0d_seq_done", i), {31'd0, seq_done}, {31'd0, vecs[i].exp_done});
            chk($sformatf("v%0d_orig_idx", i), orig_idx, vecs[i].exp_oidx);
            chk($sformatf("v%0d_dup_idx", i), dup_idx, vecs[i].exp_didx);
            step();
        end

        // dup_gap=0: DUP on the very next cycle, dup_idx=1 after a counter flush.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        dup_gap = 8'd0;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        push_wr(16'h1234, 1'b1, 1'b0);
        push_wr(16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        chk("g0_is_orig", {31'd0, bus.is_orig}, 32'd1);
        chk("g0_seq_done_cleared", {31'd0, seq_done}, 32'd0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("g0_dup_stall", {31'd0, bus.host_ready}, 32'd0);
        chk("g0_is_dup", {31'd0, bus.is_dup}, 32'd1);
        chk("g0_orig_idx", orig_idx, 32'd0);
        step();
        @(negedge clk);
        chk("g0_dup_idx", dup_idx, 32'd1);
        step();

        // Flush during GAP, then a clean re-arm (start held high while ARMED).
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        dup_gap = 8'd3;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
        push_wr(16'h1111, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0);
        push_wr(16'h2222, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b0);
        @(negedge clk);
        chk("fl_host_ready", {31'd0, bus.host_ready}, 32'd0);
        chk("fl_wen", {31'd0, bus.wen_out}, 32'd0);
        step();
        dup_gap = 8'd1;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("fl_orig_idx", orig_idx, ONES);
        chk("fl_dup_idx", dup_idx, ONES);
        step();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 16'h4444, 1'b0);
        push_wr(16'h4444, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
        push_wr(16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        chk("rearm_orig_idx", orig_idx, 32'd0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h6666, 1'b0);
        push_wr(16'h4444, 1'b0, 1'b1);
        @(negedge clk);
        chk("rearm_dup_stall", {31'd0, bus.host_ready}, 32'd0);
        step();
        push_wr(16'h6666, 1'b0, 1'b0);
        @(negedge clk);
        chk("rearm_dup_idx", dup_idx, 32'd2);
        chk("rearm_drain_ready", {31'd0, bus.host_ready}, 32'd1);
        step();

        // clk_en low for 3 cycles while in DUP.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        dup_gap = 8'd0;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
        push_wr(16'h7777, 1'b1, 1'b0);
        push_wr(16'h7777, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'h8888, 1'b0);
            @(negedge clk);
            chk($sformatf("ce%0d_host_ready", k), {31'd0, bus.host_ready}, 32'd0);
            chk($sformatf("ce%0d_wen", k), {31'd0, bus.wen_out}, 32'd0);
            step();
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h8888, 1'b0);
        @(negedge clk);
        chk("ce_dup_issue", {31'd0, bus.is_dup}, 32'd1);
        chk("ce_dup_data", {16'd0, bus.data_out}, 32'h0000_7777);
        step();
        push_wr(16'h8888, 1'b0, 1'b0);
        @(negedge clk);
        chk("ce_dup_idx", dup_idx, 32'd1);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        chk("ce_not_done_yet", {31'd0, seq_done}, 32'd0);
        step();
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("ce_seq_done", {31'd0, seq_done}, 32'd1);
        step();

        // Reset asserted mid-sequence: back to IDLE, no DUP afterwards.
        dup_gap = 8'd2;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
        push_wr(16'h9999, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_orig_idx", orig_idx, ONES);
        chk("mid_rst_seq_done", {31'd0, seq_done}, 32'd0);
        step();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0);
        push_wr(16'hAAAA, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("mid_rst_no_dup", {31'd0, bus.wen_out}, 32'd0);
        step();

`ifdef AQED_WATCHDOG_EN
        // Arm with no host writes: timeout after 16 cycles, start clears it.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (15) step();
        @(negedge clk);
        chk("wd_not_yet", {31'd0, timeout}, 32'd0);
        step();
        @(negedge clk);
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        step();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("wd_cleared", {31'd0, timeout}, 32'd0);
        step();
`endif

        @(negedge clk);
        chk("sb_all_writes_seen", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
